// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator.
// Accepts a raster-order pixel stream, keeps two line buffers of history and
// emits one 3x3 window per fully-interior pixel through a single registered
// output stage. The final window of each frame is flagged with out_last.
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9*DATA_W-1:0] out_window,
    output logic                out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              acc;
    logic              col_end;
    logic              row_end;
    logic              emit;

    // Line buffers: linebuf1 holds the row two above the input, linebuf0 the row above.
    logic [DATA_W-1:0] linebuf0 [IMG_W];
    logic [DATA_W-1:0] linebuf1 [IMG_W];

    // Current 3x3 window, [row][col], row 0 on top, col 0 on the left.
    logic [DATA_W-1:0] win      [3][3];
    logic [DATA_W-1:0] win_next [3][3];
    logic [9*DATA_W-1:0] win_flat;

    // A single output register: stall upstream only while a window is held.
    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    assign col_end  = (col == COL_MAX);
    assign row_end  = (row == ROW_MAX);
    // Gating on row>=2 and col>=2 keeps windows from straddling rows or frames.
    assign emit     = acc && (row >= RW'(2)) && (col >= CW'(2));

    // Shift the window left by one column and append the new right column.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_next[r][c] = win[r][c];
            end
        end
        for (int r = 0; r < 3; r++) begin
            win_next[r][0] = win[r][1];
            win_next[r][1] = win[r][2];
        end
        win_next[0][2] = linebuf1[col];
        win_next[1][2] = linebuf0[col];
        win_next[2][2] = in_data;
    end

    // Pack the next window into the output bus layout.
    always_comb begin
        // NOTE: blocking '=' belongs in combinational blocks; clocked state uses '<='.
        win_flat = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_flat[(r*3 + c)*DATA_W +: DATA_W] = win_next[r][c];
            end
        end
    end

    // Raster position counters, advancing only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffer and window storage update on each accepted pixel.
    // NOTE: storage arrays are left unreset; every entry is written before it can reach out_window.
    always_ff @(posedge clk) begin
        if (acc) begin
            linebuf1[col] <= linebuf0[col];
            linebuf0[col] <= in_data;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= win_next[r][c];
                end
            end
        end
    end

    // Output stage: load on emit, hold while stalled, drop once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_last   <= 1'b0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            out_window <= win_flat;
            out_last   <= row_end && col_end;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed bench for conv_window_gen.
// A 4x4 instance covers latency, stall, back-to-back frames and reset; a 32x32
// instance streams a full frame with random gaps and random back-pressure.
module tb_conv_window_gen;

    typedef struct packed {
        logic [71:0] win;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    logic [7:0]  s_in_data;
    logic [71:0] s_out_window;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [7:0]  b_in_data;
    logic [71:0] b_out_window;

    conv_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_window (s_out_window),
        .out_last   (s_out_last)
    );

    conv_window_gen #(.DATA_W(8), .IMG_W(32), .IMG_H(32)) u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_window (b_out_window),
        .out_last   (b_out_last)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t s_q[$];
    exp_t b_q[$];
    exp_t s_e, b_e;
    int   s_pos    = 0;
    int   s_wins   = 0;
    int   s_lasts  = 0;
    int   b_wins   = 0;
    int   b_lasts  = 0;
    bit   s_lat_chk = 1'b0;
    bit   b_rand    = 1'b0;
    int   w0, l0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window ending at (row,col) of a frame whose pixel (r,c) is base + r*w + c.
    function automatic logic [71:0] exp_win(input int base, input int w, input int row, input int col);
        logic [71:0] v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v[(r*3 + c)*8 +: 8] = 8'((base + (row - 2 + r)*w + (col - 2 + c)) & 255);
            end
        end
        return v;
    endfunction

    // Scoreboards: compare every handshaken window with the expected queue.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && s_out_valid && s_out_ready) begin
            s_wins++;
            if (s_out_last) s_lasts++;
            if (s_q.size() == 0) begin
                check("s_unexpected_window", 72'(s_q.size()), 72'(1));
            end else begin
                s_e = s_q.pop_front();
                check("s_window", s_out_window, s_e.win);
                check("s_last", 72'(s_out_last), 72'(s_e.last));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && b_out_valid && b_out_ready) begin
            b_wins++;
            if (b_out_last) b_lasts++;
            if (b_q.size() == 0) begin
                check("b_unexpected_window", 72'(b_q.size()), 72'(1));
            end else begin
                b_e = b_q.pop_front();
                check("b_window", b_out_window, b_e.win);
                check("b_last", 72'(b_out_last), 72'(b_e.last));
            end
        end
    end

    // Random back-pressure for the large instance, driven on the falling edge.
    initial forever begin
        @(negedge clk);
        b_out_ready = b_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Send n pixels to the 4x4 instance, values base + position in frame.
    task automatic s_send(input int base, input int n);
        bit ok, rdy;
        int r, c;
        for (int i = 0; i < n; i++) begin
            r = s_pos / 4;
            c = s_pos % 4;
            s_in_valid = 1'b1;
            s_in_data  = 8'(base + s_pos);
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                #1;
                rdy = s_in_ready;
                @(posedge clk);
                if (rdy) begin
                    ok = 1'b1;
                    if (r >= 2 && c >= 2)
                        s_q.push_back('{win: exp_win(base, 4, r, c), last: 1'(r == 3 && c == 3)});
                    s_pos = (s_pos + 1) % 16;
                    if (s_lat_chk) begin
                        #1;
                        check("s_lat_valid", 72'(s_out_valid), 72'(r >= 2 && c >= 2));
                        if (r >= 2 && c >= 2) begin
                            check("s_lat_window", s_out_window, exp_win(base, 4, r, c));
                            check("s_lat_last", 72'(s_out_last), 72'(r == 3 && c == 3));
                        end
                    end
                end
                @(negedge clk);
            end
            check("s_accept_timeout", 72'(ok), 72'(1));
        end
        s_in_valid = 1'b0;
    endtask

    task automatic s_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 72'(s_out_valid), 72'(0));
        check("rst_out_last", 72'(s_out_last), 72'(0));
        check("rst_out_window", s_out_window, 72'(0));
        s_q.delete();
        s_pos = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        repeat (10) @(negedge clk);
    endtask

    task automatic s_counts(input string tag, input int nw, input int nl);
        check({tag, "_windows"}, 72'(s_wins - w0), 72'(nw));
        check({tag, "_lasts"}, 72'(s_lasts - l0), 72'(nl));
        check({tag, "_queue_empty"}, 72'(s_q.size()), 72'(0));
    endtask

    // Hold the first window for five cycles, then release it together with the next pixel.
    task automatic stall_first();
        bit          seen;
        logic [71:0] held;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (s_out_valid) seen = 1'b1;
        end
        check("t2_seen", 72'(seen), 72'(1));
        s_out_ready = 1'b0;
        held = s_out_window;
        check("t2_first_window", held, exp_win(0, 4, 2, 2));
        for (int k = 0; k < 5; k++) begin
            #2;
            check("t2_hold_window", s_out_window, exp_win(0, 4, 2, 2));
            check("t2_hold_valid", 72'(s_out_valid), 72'(1));
            check("t2_in_ready_low", 72'(s_in_ready), 72'(0));
            @(negedge clk);
        end
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t6_next_valid", 72'(s_out_valid), 72'(1));
        check("t6_next_window", s_out_window, exp_win(0, 4, 2, 3));
        check("t6_next_last", 72'(s_out_last), 72'(0));
    endtask

    initial begin
        bit ok, rdy;
        int r, c;
        rst_n       = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;

        #12;
        check("reset_out_valid", 72'(s_out_valid), 72'(0));
        check("reset_out_last", 72'(s_out_last), 72'(0));
        check("reset_out_window", s_out_window, 72'(0));
        check("reset_in_ready", 72'(s_in_ready), 72'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single 4x4 frame, free-flowing output, latency checked per pixel.
        w0 = s_wins; l0 = s_lasts;
        s_lat_chk = 1'b1;
        s_send(0, 16);
        s_lat_chk = 1'b0;
        drain();
        s_counts("t1", 4, 1);

        // Tests 2 and 6: first window stalled five cycles, released with a pixel accept.
        w0 = s_wins; l0 = s_lasts;
        fork
            s_send(0, 16);
            stall_first();
        join
        drain();
        s_counts("t2", 4, 1);

        // Test 4: two back-to-back frames.
        w0 = s_wins; l0 = s_lasts;
        s_send(0, 16);
        s_send(16, 16);
        drain();
        s_counts("t4", 8, 2);

        // Test 5: reset after seven pixels, then a clean frame.
        s_send(0, 7);
        s_reset();
        w0 = s_wins; l0 = s_lasts;
        s_lat_chk = 1'b1;
        s_send(0, 16);
        s_lat_chk = 1'b0;
        drain();
        s_counts("t5", 4, 1);

        // Reset while a window is presented: it must be dropped.
        s_send(0, 11);
        check("t5b_pre_reset_valid", 72'(s_out_valid), 72'(1));
        s_reset();
        w0 = s_wins; l0 = s_lasts;
        s_send(0, 16);
        drain();
        s_counts("t5b", 4, 1);

        // Test 3: full 32x32 frame with random input gaps and back-pressure.
        b_rand = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            r = i / 32;
            c = i % 32;
            while ($urandom_range(0, 3) == 0) begin
                b_in_valid = 1'b0;
                @(negedge clk);
            end
            b_in_valid = 1'b1;
            b_in_data  = 8'((r*32 + c) & 255);
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                #1;
                rdy = b_in_ready;
                @(posedge clk);
                if (rdy) begin
                    ok = 1'b1;
                    if (r >= 2 && c >= 2)
                        b_q.push_back('{win: exp_win(0, 32, r, c), last: 1'(r == 31 && c == 31)});
                end
                @(negedge clk);
            end
            if (!ok) check("b_accept_timeout", 72'(ok), 72'(1));
        end
        b_in_valid = 1'b0;
        b_rand = 1'b0;
        drain();
        check("t3_windows", 72'(b_wins), 72'(900));
        check("t3_lasts", 72'(b_lasts), 72'(1));
        check("t3_queue_empty", 72'(b_q.size()), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
